// File: rtl/dsp_pkg.sv
// -----------------------------------------------------------------------------
// dsp_pkg
// Shared definitions for the DSP multiply-add integration:
//   - default widths of the P result stream and of the frame accumulator
//   - state encoding of the frame accumulator flow-control FSM
// -----------------------------------------------------------------------------
package dsp_pkg;

  localparam int DSP_P_W   = 48;
  localparam int DSP_ACC_W = 56;

  // ACC  : accumulating, samples flow freely
  // STALL: last sample of a frame is waiting for the output register to drain
  typedef enum logic {
    ACC   = 1'b0,
    STALL = 1'b1
  } state_e;

endpackage

// File: rtl/dsp_frame_accumulator_sat_add_u.sv
// -----------------------------------------------------------------------------
// sat_add_u
// W-bit unsigned saturating adder (purely combinational).
// Ports:
//   a_i   : addend A
//   b_i   : addend B
//   sum_o : a_i + b_i, clamped to all ones when the true sum exceeds 2^W-1
//   ovf_o : high when the clamp was applied
// -----------------------------------------------------------------------------
module sat_add_u #(
  parameter int W = 56
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         ovf_o
);

  logic [W:0] full_sum;

  // One extra bit catches the carry out, which is exactly the overflow case.
  assign full_sum = {1'b0, a_i} + {1'b0, b_i};
  assign ovf_o    = full_sum[W];
  assign sum_o    = full_sum[W] ? {W{1'b1}} : full_sum[W-1:0];

endmodule

// File: rtl/dsp_frame_accumulator.sv
// -----------------------------------------------------------------------------
// dsp_frame_accumulator
// Sums LEN consecutive unsigned P samples into one frame total with
// saturation, and presents the total on a one-entry valid/ready register.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   p_in/p_valid/p_ready  : incoming sample stream (accept = valid && ready)
//   clear                 : synchronous abort of the frame in progress
//   sum_out/sum_ovf       : frame total and its saturation flag
//   sum_valid/sum_ready   : output register handshake
//   frame_cnt             : number of frames loaded into the output register
// -----------------------------------------------------------------------------
module dsp_frame_accumulator
  import dsp_pkg::*;
#(
  parameter int DATA_W = DSP_P_W,
  parameter int ACC_W  = DSP_ACC_W,
  parameter int LEN    = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] p_in,
  input  logic              p_valid,
  output logic              p_ready,
  input  logic              clear,
  output logic [ACC_W-1:0]  sum_out,
  output logic              sum_ovf,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int IDX_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               frame_ovf_q, frame_ovf_d;
  logic [ACC_W-1:0]   sum_out_q, sum_out_d;
  logic               sum_ovf_q, sum_ovf_d;
  logic               sum_valid_q, sum_valid_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;

  logic               is_last;
  logic               hold_last;
  logic               accept;
  logic               last_accept;
  logic               drain;
  logic [ACC_W-1:0]   add_sum;
  logic               add_ovf;

  sat_add_u #(
    .W (ACC_W)
  ) u_sat_add (
    .a_i   (acc_q),
    .b_i   (ACC_W'(p_in)),
    .sum_o (add_sum),
    .ovf_o (add_ovf)
  );

  assign is_last     = (idx_q == LAST_IDX);
  // The last sample can only be taken if the output register is free now
  // or is being drained in this very cycle.
  assign hold_last   = is_last && sum_valid_q && !sum_ready;
  assign accept      = p_valid && p_ready;
  assign last_accept = accept && is_last;
  assign drain       = sum_valid_q && sum_ready;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACC;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ACC;
    end else begin
      case (state_q)
        ACC:     if (hold_last) state_d = STALL;
        STALL:   if (sum_ready) state_d = ACC;
        default: state_d = ACC;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  // In STALL the held last sample goes through as soon as the output
  // register drains, so ready follows sum_ready combinationally.
  always_comb begin
    p_ready = 1'b0;
    if (!rst && !clear) begin
      p_ready = (state_q == ACC) ? !hold_last : sum_ready;
    end
  end

  // ---------------- Accumulator datapath ----------------
  always_comb begin
    acc_d       = acc_q;
    idx_d       = idx_q;
    frame_ovf_d = frame_ovf_q;
    if (clear) begin
      acc_d       = '0;
      idx_d       = '0;
      frame_ovf_d = 1'b0;
    end else if (accept) begin
      if (is_last) begin
        acc_d       = '0;
        idx_d       = '0;
        frame_ovf_d = 1'b0;
      end else begin
        acc_d       = add_sum;
        idx_d       = idx_q + IDX_W'(1);
        frame_ovf_d = frame_ovf_q | add_ovf;
      end
    end
  end

  // ---------------- Output register ----------------
  // A load wins over a drain, so a coincident drain+load leaves valid high.
  always_comb begin
    sum_out_d   = sum_out_q;
    sum_ovf_d   = sum_ovf_q;
    sum_valid_d = sum_valid_q;
    frame_cnt_d = frame_cnt_q;
    if (last_accept) begin
      sum_out_d   = add_sum;
      sum_ovf_d   = frame_ovf_q | add_ovf;
      sum_valid_d = 1'b1;
      frame_cnt_d = frame_cnt_q + CNT_W'(1);
    end else if (drain) begin
      sum_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      idx_q       <= '0;
      frame_ovf_q <= 1'b0;
      sum_out_q   <= '0;
      sum_ovf_q   <= 1'b0;
      sum_valid_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      frame_ovf_q <= frame_ovf_d;
      sum_out_q   <= sum_out_d;
      sum_ovf_q   <= sum_ovf_d;
      sum_valid_q <= sum_valid_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign sum_out   = sum_out_q;
  assign sum_ovf   = sum_ovf_q;
  assign sum_valid = sum_valid_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_dsp_frame_accumulator.sv
// -----------------------------------------------------------------------------
// tb_dsp_frame_accumulator
// Self-checking bench for dsp_frame_accumulator with LEN=4, DATA_W=48,
// ACC_W=49, CNT_W=2. Expected frame results are queued when the last sample
// of a frame is accepted and compared when the output handshake completes.
// -----------------------------------------------------------------------------
module tb_dsp_frame_accumulator;

  localparam int DATA_W = 48;
  localparam int ACC_W  = 49;
  localparam int LEN    = 4;
  localparam int CNT_W  = 2;

  localparam logic [DATA_W-1:0] MAXP = {DATA_W{1'b1}};
  localparam logic [ACC_W-1:0]  MAXS = {ACC_W{1'b1}};

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] p_in = '0;
  logic              p_valid = 1'b0;
  logic              p_ready;
  logic              clear = 1'b0;
  logic [ACC_W-1:0]  sum_out;
  logic              sum_ovf;
  logic              sum_valid;
  logic              sum_ready = 1'b0;
  logic [CNT_W-1:0]  frame_cnt;

  always #5 clk = ~clk;

  dsp_frame_accumulator #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .LEN    (LEN),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .p_in      (p_in),
    .p_valid   (p_valid),
    .p_ready   (p_ready),
    .clear     (clear),
    .sum_out   (sum_out),
    .sum_ovf   (sum_ovf),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready),
    .frame_cnt (frame_cnt)
  );

  typedef struct {
    logic [ACC_W-1:0] sum;
    logic             ovf;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  typedef struct {
    logic [3:0][DATA_W-1:0] s;
    logic [ACC_W-1:0]       sum;
    logic                   ovf;
  } vec_t;

  exp_t             sb[$];
  vec_t             tab[6];
  int               tests = 0;
  int               fails = 0;
  int               bidx = 0;
  logic [CNT_W-1:0] exp_cnt = '0;
  logic [ACC_W-1:0] pend_sum = '0;
  logic             pend_ovf = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One clock: sample the output handshake and the input accept at the
  // falling edge, then return just after the next rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (sum_valid && sum_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_spurious: got sum_out=%0h want no output", sum_out);
      end else begin
        e = sb.pop_front();
        chk("sb_sum", 64'(sum_out), 64'(e.sum));
        chk("sb_ovf", 64'(sum_ovf), 64'(e.ovf));
        chk("sb_cnt", 64'(frame_cnt), 64'(e.cnt));
        $display("[TB] frame out sum=%0h ovf=%0d cnt=%0d", sum_out, sum_ovf, frame_cnt);
      end
    end
    if (clear) begin
      bidx = 0;
    end else if (p_valid && p_ready) begin
      if (bidx == LEN - 1) begin
        bidx = 0;
        exp_cnt = exp_cnt + 1'b1;
        e.sum = pend_sum;
        e.ovf = pend_ovf;
        e.cnt = exp_cnt;
        sb.push_back(e);
      end else begin
        bidx++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [DATA_W-1:0] v);
    p_valid = 1'b1;
    p_in    = v;
    #1;
    chk("feed_ready", 64'(p_ready), 64'd1);
    tick();
  endtask

  // Asserts rst in the middle of a clock period and checks the outputs
  // clear without waiting for an edge.
  task automatic do_reset();
    #3 rst = 1'b1;
    #1;
    chk("rst_valid", 64'(sum_valid), 64'd0);
    chk("rst_cnt",   64'(frame_cnt), 64'd0);
    chk("rst_sum",   64'(sum_out),   64'd0);
    chk("rst_ovf",   64'(sum_ovf),   64'd0);
    chk("rst_ready", 64'(p_ready),   64'd0);
    sb.delete();
    bidx    = 0;
    exp_cnt = '0;
    p_valid = 1'b0;
    clear   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_ready_after", 64'(p_ready), 64'd1);
  endtask

  initial begin
    tab[0] = '{s: {48'd4, 48'd3, 48'd2, 48'd1}, sum: 49'd10, ovf: 1'b0};
    tab[1] = '{s: {MAXP, MAXP, MAXP, MAXP},     sum: MAXS,   ovf: 1'b1};
    tab[2] = '{s: {48'd1, 48'd1, 48'd1, 48'd1}, sum: 49'd4,  ovf: 1'b0};
    tab[3] = '{s: {48'd0, 48'd2, MAXP, MAXP},   sum: MAXS,   ovf: 1'b1};
    tab[4] = '{s: {48'd0, 48'd1, MAXP, MAXP},   sum: MAXS,   ovf: 1'b0};
    tab[5] = '{s: {48'd0, 48'd0, 48'd0, 48'd0}, sum: 49'd0,  ovf: 1'b0};

    // Reset, then the table of back-to-back frames with free drain;
    // frame_cnt runs 1,2,3,0,1,2.
    do_reset();
    sum_ready = 1'b1;
    for (int f = 0; f < 6; f++) begin
      pend_sum = tab[f].sum;
      pend_ovf = tab[f].ovf;
      for (int k = 0; k < LEN; k++) feed(tab[f].s[k]);
    end
    p_valid = 1'b0;
    tick();
    chk("one_cycle_valid", 64'(sum_valid), 64'd0);
    tick();

    // Reset while a result is held in the output register.
    sum_ready = 1'b0;
    pend_sum  = 49'd4;
    pend_ovf  = 1'b0;
    for (int k = 0; k < LEN; k++) feed(48'd1);
    p_valid = 1'b0;
    chk("held_valid", 64'(sum_valid), 64'd1);
    chk("held_cnt",   64'(frame_cnt), 64'd3);
    do_reset();

    // Stall on the last sample while the output is occupied, then drain
    // and load in the same cycle.
    sum_ready = 1'b0;
    pend_sum  = 49'd4;
    pend_ovf  = 1'b0;
    for (int k = 0; k < 2 * LEN - 1; k++) feed(48'd1);
    p_valid = 1'b1;
    p_in    = 48'd1;
    #1;
    chk("stall_ready", 64'(p_ready), 64'd0);
    tick();
    chk("stall_hold_valid", 64'(sum_valid), 64'd1);
    chk("stall_hold_sum",   64'(sum_out),   64'd4);
    #1;
    chk("stall_ready2", 64'(p_ready), 64'd0);
    sum_ready = 1'b1;
    #1;
    chk("stall_release_ready", 64'(p_ready), 64'd1);
    tick();
    p_valid   = 1'b0;
    sum_ready = 1'b0;
    #1;
    chk("nobubble_valid", 64'(sum_valid), 64'd1);
    chk("nobubble_sum",   64'(sum_out),   64'd4);
    chk("nobubble_cnt",   64'(frame_cnt), 64'd2);
    sum_ready = 1'b1;
    tick();
    tick();

    // clear drops the partial frame and the sample offered with it.
    do_reset();
    sum_ready = 1'b1;
    feed(48'd7);
    feed(48'd7);
    p_valid = 1'b1;
    p_in    = 48'd9;
    clear   = 1'b1;
    #1;
    chk("clear_ready", 64'(p_ready), 64'd0);
    tick();
    clear    = 1'b0;
    pend_sum = 49'd20;
    pend_ovf = 1'b0;
    for (int k = 0; k < LEN; k++) feed(48'd5);
    p_valid = 1'b0;
    tick();
    tick();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
